// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing, colour, arena and direction definitions
package vga_pkg;

  // 640x480@60 horizontal timing, in pixels
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FP         = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BP         = 10'd48;
  localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_VISIBLE + H_FP + H_SYNC;

  // 640x480@60 vertical timing, in lines
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FP         = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BP         = 10'd33;
  localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FP;
  localparam logic [9:0] V_SYNC_END   = V_VISIBLE + V_FP + V_SYNC;

  // Arena geometry: the playfield is the whole visible area inside the walls
  localparam logic [9:0] ARENA_W      = H_VISIBLE;
  localparam logic [9:0] ARENA_H      = V_VISIBLE;
  localparam logic [9:0] DEF_WALL     = 10'd16;
  localparam logic [9:0] DEF_SPRITE   = 10'd16;

  // Spawn points shared by reset and collision
  localparam logic [9:0] PLAYER_X0    = 10'd304;
  localparam logic [9:0] PLAYER_Y0    = 10'd224;
  localparam logic [9:0] GHOST_X0     = 10'd16;
  localparam logic [9:0] GHOST_Y0     = 10'd16;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } rgb_t;

  localparam rgb_t COL_BLACK  = '{r: 10'h000, g: 10'h000, b: 10'h000};
  localparam rgb_t COL_YELLOW = '{r: 10'h3FF, g: 10'h3FF, b: 10'h000};
  localparam rgb_t COL_RED    = '{r: 10'h3FF, g: 10'h000, b: 10'h000};
  localparam rgb_t COL_BLUE   = '{r: 10'h000, g: 10'h000, b: 10'h3FF};

  // Clockwise order, so +1 turns clockwise and -1 counter-clockwise
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 640x480@60 raster counters and sync decode
module vga_timing
  import vga_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       pe,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hs,
  output logic       vs,
  output logic       visible,
  output logic       frame_tick
);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;

  // Advance the raster one pixel per enable; line count steps on line wrap
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pe) begin
      if (hcount_q == H_TOTAL - 10'd1) begin
        hcount_d = 10'd0;
        vcount_d = (vcount_q == V_TOTAL - 10'd1) ? 10'd0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  // Raster position registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hcount_q <= 10'd0;
      vcount_q <= 10'd0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign hcount     = hcount_q;
  assign vcount     = vcount_q;
  assign hs         = !((hcount_q >= H_SYNC_START) && (hcount_q < H_SYNC_END));
  assign vs         = !((vcount_q >= V_SYNC_START) && (vcount_q < V_SYNC_END));
  assign visible    = (hcount_q < H_VISIBLE) && (vcount_q < V_VISIBLE);
  // First pixel of vertical blank: game state may change without tearing
  assign frame_tick = pe && (hcount_q == 10'd0) && (vcount_q == V_VISIBLE);

endmodule

// File: rtl/system_de2_top.sv
// rtl/system_de2_top.sv - DE2 Pacman remix: VGA timing, player/ghost game, renderer
module system_de2_top
  import vga_pkg::*;
#(
  parameter logic [9:0] SPRITE = DEF_SPRITE,
  parameter logic [9:0] WALL   = DEF_WALL,
  parameter logic [9:0] PSTEP  = 10'd2,
  parameter logic [9:0] GSTEP  = 10'd1
) (
  input  logic       CLOCK_50,
  input  logic [2:0] KEY,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK,
  output logic       VGA_SYNC,
  output logic [9:0] VGA_R,
  output logic [9:0] VGA_G,
  output logic [9:0] VGA_B
);

  // Player top-left corner stays inside the walls
  localparam logic [9:0] X_MIN = WALL;
  localparam logic [9:0] X_MAX = ARENA_W - WALL - SPRITE;
  localparam logic [9:0] Y_MIN = WALL;
  localparam logic [9:0] Y_MAX = ARENA_H - WALL - SPRITE;

  logic       reset;
  logic       pe;
  logic [9:0] hcount, vcount;
  logic       hs, vs, visible, frame_tick;

  assign reset = KEY[0];

  // ---------------- pixel clock ----------------
  logic vga_clk_q, vga_clk_d;

  // Divide-by-two toggle; the enable marks the cycle where it rises
  always_comb begin
    vga_clk_d = ~vga_clk_q;
  end

  // Pixel clock register
  always_ff @(posedge CLOCK_50) begin
    if (reset) vga_clk_q <= 1'b0;
    else       vga_clk_q <= vga_clk_d;
  end

  assign pe = ~vga_clk_q;

  vga_timing u_timing (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .pe         (pe),
    .hcount     (hcount),
    .vcount     (vcount),
    .hs         (hs),
    .vs         (vs),
    .visible    (visible),
    .frame_tick (frame_tick)
  );

  // ---------------- key synchronisers ----------------
  // Bit 1 = KEY[2] (clockwise), bit 0 = KEY[1] (counter-clockwise)
  logic [1:0] key_meta_q, key_meta_d;
  logic [1:0] key_sync_q, key_sync_d;
  logic [1:0] key_prev_q, key_prev_d;
  logic [1:0] key_rise;

  // Two-flop synchroniser followed by a delay stage for edge detection
  always_comb begin
    key_meta_d = KEY[2:1];
    key_sync_d = key_meta_q;
    key_prev_d = key_sync_q;
  end

  // Key synchroniser registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_meta_q <= 2'b00;
      key_sync_q <= 2'b00;
      key_prev_q <= 2'b00;
    end else begin
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      key_prev_q <= key_prev_d;
    end
  end

  assign key_rise = key_sync_q & ~key_prev_q;

  // ---------------- game state ----------------
  logic [9:0] px_q, px_d, py_q, py_d;
  logic [9:0] gx_q, gx_d, gy_q, gy_d;
  dir_t       dir_q, dir_d;
  logic [1:0] dir_bits;
  logic [9:0] px_mv, py_mv, gx_mv, gy_mv;
  logic [9:0] dx, dy;
  logic       hit;

  // Turning on key edges, per-frame movement, clamping and collision respawn
  always_comb begin
    dir_bits = dir_q;
    dir_d    = dir_q;
    unique case (key_rise)
      2'b10:   dir_d = dir_t'(dir_bits + 2'd1);
      2'b01:   dir_d = dir_t'(dir_bits - 2'd1);
      default: dir_d = dir_q;
    endcase

    // Clamp tests are made before the add/subtract so no value can wrap
    px_mv = px_q;
    py_mv = py_q;
    unique case (dir_q)
      DIR_RIGHT: px_mv = (px_q >= X_MAX - PSTEP) ? X_MAX : px_q + PSTEP;
      DIR_LEFT:  px_mv = (px_q <= X_MIN + PSTEP) ? X_MIN : px_q - PSTEP;
      DIR_DOWN:  py_mv = (py_q >= Y_MAX - PSTEP) ? Y_MAX : py_q + PSTEP;
      DIR_UP:    py_mv = (py_q <= Y_MIN + PSTEP) ? Y_MIN : py_q - PSTEP;
      default:   px_mv = px_q;
    endcase

    // Ghost chases where the player was before this frame's move
    gx_mv = gx_q;
    gy_mv = gy_q;
    if (gx_q < px_q)      gx_mv = gx_q + GSTEP;
    else if (gx_q > px_q) gx_mv = gx_q - GSTEP;
    if (gy_q < py_q)      gy_mv = gy_q + GSTEP;
    else if (gy_q > py_q) gy_mv = gy_q - GSTEP;

    dx  = (px_mv >= gx_mv) ? px_mv - gx_mv : gx_mv - px_mv;
    dy  = (py_mv >= gy_mv) ? py_mv - gy_mv : gy_mv - py_mv;
    hit = (dx < SPRITE) && (dy < SPRITE);

    px_d = px_q;
    py_d = py_q;
    gx_d = gx_q;
    gy_d = gy_q;
    if (frame_tick) begin
      if (hit) begin
        px_d  = PLAYER_X0;
        py_d  = PLAYER_Y0;
        gx_d  = GHOST_X0;
        gy_d  = GHOST_Y0;
        dir_d = DIR_RIGHT;
      end else begin
        px_d = px_mv;
        py_d = py_mv;
        gx_d = gx_mv;
        gy_d = gy_mv;
      end
    end
  end

  // Game state registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      px_q  <= PLAYER_X0;
      py_q  <= PLAYER_Y0;
      gx_q  <= GHOST_X0;
      gy_q  <= GHOST_Y0;
      dir_q <= DIR_RIGHT;
    end else begin
      px_q  <= px_d;
      py_q  <= py_d;
      gx_q  <= gx_d;
      gy_q  <= gy_d;
      dir_q <= dir_d;
    end
  end

  // ---------------- renderer ----------------
  logic in_player, in_ghost, in_wall;
  rgb_t pix;
  rgb_t rgb_q, rgb_d;
  logic hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;

  // Colour of the current raster pixel, player over ghost over wall
  always_comb begin
    in_player = (hcount >= px_q) && (hcount < px_q + SPRITE) &&
                (vcount >= py_q) && (vcount < py_q + SPRITE);
    in_ghost  = (hcount >= gx_q) && (hcount < gx_q + SPRITE) &&
                (vcount >= gy_q) && (vcount < gy_q + SPRITE);
    in_wall   = (hcount < WALL) || (hcount >= ARENA_W - WALL) ||
                (vcount < WALL) || (vcount >= ARENA_H - WALL);
    if (in_player)     pix = COL_YELLOW;
    else if (in_ghost) pix = COL_RED;
    else if (in_wall)  pix = COL_BLUE;
    else               pix = COL_BLACK;

    hs_d    = hs_q;
    vs_d    = vs_q;
    blank_d = blank_q;
    rgb_d   = rgb_q;
    if (pe) begin
      hs_d    = hs;
      vs_d    = vs;
      blank_d = visible;
      rgb_d   = visible ? pix : COL_BLACK;
    end
  end

  // Video output registers: syncs, blank and colour stay aligned
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= COL_BLACK;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      rgb_q   <= rgb_d;
    end
  end

  assign VGA_CLK   = vga_clk_q;
  assign VGA_HS    = hs_q;
  assign VGA_VS    = vs_q;
  assign VGA_BLANK = blank_q;
  assign VGA_SYNC  = 1'b0;
  assign VGA_R     = rgb_q.r;
  assign VGA_G     = rgb_q.g;
  assign VGA_B     = rgb_q.b;

endmodule

// File: tb/tb_system_de2_top.sv
// tb/tb_system_de2_top.sv - scoreboard bench for system_de2_top
module tb_system_de2_top;

  logic       CLOCK_50 = 1'b0;
  logic [2:0] KEY = 3'b001;
  logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC;
  logic [9:0] VGA_R, VGA_G, VGA_B;

  always #10 CLOCK_50 = ~CLOCK_50;

  system_de2_top dut (
    .CLOCK_50  (CLOCK_50),
    .KEY       (KEY),
    .VGA_CLK   (VGA_CLK),
    .VGA_HS    (VGA_HS),
    .VGA_VS    (VGA_VS),
    .VGA_BLANK (VGA_BLANK),
    .VGA_SYNC  (VGA_SYNC),
    .VGA_R     (VGA_R),
    .VGA_G     (VGA_G),
    .VGA_B     (VGA_B)
  );

  typedef struct {
    bit    is_state;
    int    x, y;
    int    e0, e1, e2, e3, e4;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sync_bad = 0;
  int   blank_bad = 0;
  int   clk_bad  = 0;
  bit   mon_on   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_state(input string name, input int px, input int py, input int dir,
                            input int gx, input int gy);
    exp_t e;
    e.is_state = 1; e.x = 0; e.y = 480;
    e.e0 = px; e.e1 = py; e.e2 = dir; e.e3 = gx; e.e4 = gy; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic push_pixel(input string name, input int x, input int y,
                            input int r, input int g, input int b);
    exp_t e;
    e.is_state = 0; e.x = x; e.y = y;
    e.e0 = r; e.e1 = g; e.e2 = b; e.e3 = 0; e.e4 = 0; e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: samples mid-low-phase, after any stimulus change at the falling edge
  initial begin : monitor
    bit   have_prev = 0;
    bit   prev_pe = 0, prev_rst = 0;
    logic prev_vclk = 1'b0;
    int   prev_h = 0, prev_v = 0;
    exp_t head;
    forever begin
      @(negedge CLOCK_50);
      #5;
      if (mon_on) begin
        if (VGA_SYNC !== 1'b0) sync_bad++;
        if (VGA_BLANK === 1'b0 && {VGA_R, VGA_G, VGA_B} !== 30'd0) blank_bad++;
        if (have_prev) begin
          if (prev_rst && VGA_CLK !== 1'b0) clk_bad++;
          if (!prev_rst && VGA_CLK === prev_vclk) clk_bad++;
        end
        if (have_prev && prev_pe && exp_q.size() > 0) begin
          head = exp_q[0];
          if (head.is_state && prev_h == 0 && prev_v == 480) begin
            void'(exp_q.pop_front());
            check({head.name, ".px"},  int'(dut.px_q),  head.e0);
            check({head.name, ".py"},  int'(dut.py_q),  head.e1);
            check({head.name, ".dir"}, int'(dut.dir_q), head.e2);
            check({head.name, ".gx"},  int'(dut.gx_q),  head.e3);
            check({head.name, ".gy"},  int'(dut.gy_q),  head.e4);
          end else if (!head.is_state && prev_h == head.x && prev_v == head.y) begin
            void'(exp_q.pop_front());
            check({head.name, ".r"}, int'(VGA_R), head.e0);
            check({head.name, ".g"}, int'(VGA_G), head.e1);
            check({head.name, ".b"}, int'(VGA_B), head.e2);
          end
        end
        have_prev = 1;
      end
      prev_rst  = KEY[0];
      prev_pe   = (VGA_CLK === 1'b0) && !KEY[0];
      prev_vclk = VGA_CLK;
      prev_h    = int'(dut.hcount);
      prev_v    = int'(dut.vcount);
    end
  end

  // Move the raster to (h,v) so distant pixels and frame ticks are reached quickly
  task automatic jump(input int h, input int v);
    @(negedge CLOCK_50);
    #2;
    force dut.u_timing.hcount_q = 10'(h);
    force dut.u_timing.vcount_q = 10'(v);
    #1;
    release dut.u_timing.hcount_q;
    release dut.u_timing.vcount_q;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic run_frame();
    jump(797, 479);
    wait_cycles(12);
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) run_frame();
  endtask

  task automatic pixel(input string name, input int x, input int y,
                       input int r, input int g, input int b);
    push_pixel(name, x, y, r, g, b);
    jump(x - 3, y);
    wait_cycles(12);
  endtask

  task automatic pulse(input logic [1:0] k);
    @(negedge CLOCK_50);
    KEY[2:1] = k;
    wait_cycles(4);
    KEY[2:1] = 2'b00;
    wait_cycles(4);
  endtask

  task automatic do_reset(input bit with_checks);
    @(negedge CLOCK_50);
    KEY = 3'b001;
    wait_cycles(3);
    if (with_checks) begin
      check("rst.vga_clk", int'(VGA_CLK),   0);
      check("rst.hs",      int'(VGA_HS),    1);
      check("rst.vs",      int'(VGA_VS),    1);
      check("rst.blank",   int'(VGA_BLANK), 0);
      check("rst.rgb",     int'({VGA_R, VGA_G, VGA_B} != 30'd0), 0);
      check("rst.hcount",  int'(dut.hcount), 0);
      check("rst.px",      int'(dut.px_q),  304);
      check("rst.gy",      int'(dut.gy_q),  16);
    end
    KEY = 3'b000;
  endtask

  // which: 0 = HS low, 1 = VS low, 2 = BLANK high
  task automatic count_level(input int which, input int ncyc, output int cnt);
    cnt = 0;
    repeat (ncyc) begin
      @(negedge CLOCK_50);
      case (which)
        0:       if (VGA_HS === 1'b0) cnt++;
        1:       if (VGA_VS === 1'b0) cnt++;
        default: if (VGA_BLANK === 1'b1) cnt++;
      endcase
    end
  endtask

  initial begin : stimulus
    int cnt;
    mon_on = 1;
    do_reset(1);

    // Sync and blank pulse widths in CLOCK_50 cycles
    jump(0, 100);    wait_cycles(4); count_level(0, 1596, cnt);  check("hs_low_per_line", cnt, 192);
    jump(700, 99);   wait_cycles(4); count_level(2, 1600, cnt);  check("blank_high_per_line", cnt, 1280);
    jump(0, 486);    wait_cycles(4); count_level(1, 12800, cnt); check("vs_low_per_frame", cnt, 3200);

    // Idle frame and rendered scene
    do_reset(0);
    push_state("idle_f1", 306, 224, 0, 17, 17);
    run_frame();
    pixel("pix_player",     310, 230, 1023, 1023, 0);
    pixel("pix_player_edge", 321, 239, 1023, 1023, 0);
    pixel("pix_past_player", 322, 230, 0, 0, 0);
    pixel("pix_wall_tl",      5,   5, 0, 0, 1023);
    pixel("pix_black",      100, 100, 0, 0, 0);
    pixel("pix_ghost",       20,  20, 1023, 0, 0);
    pixel("pix_wall_right", 630, 300, 0, 0, 1023);
    pixel("pix_wall_bottom", 320, 470, 0, 0, 1023);

    // Turning
    do_reset(0);
    pulse(2'b10);
    push_state("turn_cw", 304, 226, 1, 17, 17);
    run_frame();
    pulse(2'b01);
    push_state("turn_ccw", 306, 226, 0, 18, 18);
    run_frame();
    pulse(2'b11);
    push_state("turn_both", 308, 226, 0, 19, 19);
    run_frame();

    // Steer UP (wraps 0 -> 3) and clamp at the top wall
    do_reset(0);
    pulse(2'b01);
    run_frames(103);
    push_state("up_f104", 304, 16, 3, 120, 52);
    run_frame();
    run_frames(15);
    push_state("up_f120", 304, 16, 3, 136, 36);
    run_frame();

    // Steer LEFT into the chasing ghost until they collide
    do_reset(0);
    pulse(2'b10);
    pulse(2'b10);
    run_frames(191);
    push_state("left_f192", 16, 224, 2, 17, 208);
    run_frame();
    push_state("collide_f193", 304, 224, 0, 16, 16);
    run_frame();
    push_state("after_collide", 306, 224, 0, 17, 17);
    run_frame();

    wait_cycles(4);
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge CLOCK_50);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: never observed, pending %0d expected 0", e.name, exp_q.size() + 1);
    end
    mon_on = 0;
    check("vga_sync_zero", sync_bad, 0);
    check("rgb_zero_in_blank", blank_bad, 0);
    check("vga_clk_period", clk_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #(20 * 200000);
    $display("FAIL watchdog: cycles 200000 expected completion");
    $fatal(1);
  end

endmodule

// File: doc/system_de2_top.md
Name: system_de2_top

Overview:
- Top level of the DE2 "Pacman remix" demo, bound directly to CLOCK_50, KEY and the DE2 VGA DAC pins.
- Generates 640x480@60 Hz VGA timing from a 25 MHz pixel enable.
- Runs a minimal game:
  - a yellow player square steered by two keys inside a blue-walled arena;
  - a red ghost chases the player.
- Renders the scene to 10-bit RGB.

Parameters:
- SPRITE, 16, player/ghost edge length in pixels.
- WALL, 16, arena border thickness in pixels.
- PSTEP, 2, player pixels moved per frame.
- GSTEP, 1, ghost pixels moved per frame per axis.

Ports:
- CLOCK_50 input 1: system clock, 50 MHz; the only clock.
- KEY input 3: KEY[0] is the reset, synchronous and active-high. KEY[1] = turn counter-clockwise, KEY[2] = turn clockwise; both active-high, asynchronous to the logic.
- VGA_CLK output 1: pixel clock, CLOCK_50/2.
- VGA_HS output 1: horizontal sync, active-low.
- VGA_VS output 1: vertical sync, active-low.
- VGA_BLANK output 1: active-low blank; 1 only in the visible region.
- VGA_SYNC output 1: tied to 0.
- VGA_R output 10: red channel.
- VGA_G output 10: green channel.
- VGA_B output 10: blue channel.

Behaviour:
- Reset (KEY[0]=1 sampled on a CLOCK_50 edge):
  - VGA_CLK=0, hcount=0, vcount=0.
  - VGA_HS=1, VGA_VS=1, VGA_BLANK=0, RGB=0.
  - Player at (304,224) with dir=RIGHT; ghost at (16,16).
  - Key synchronisers cleared.
- Pixel enable (pe):
  - A toggle flop drives VGA_CLK.
  - pe is asserted on the CLOCK_50 cycle where VGA_CLK goes 0->1, i.e. every 2nd cycle.
  - All timing and game state advance only on pe.
- Horizontal timing: hcount 0..799.
  - Visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: vcount 0..524, incremented when hcount wraps.
  - Visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Output registering:
  - HS, VS, BLANK and RGB are registered together on pe, one pixel after their counter values.
  - RGB is forced to 0 whenever blank.
- Colour priority:
  - Player (yellow: R=3FF, G=3FF, B=0) over ghost (red: R=3FF) over wall (blue: B=3FF) over black.
  - Wall region: x<WALL, x>=640-WALL, y<WALL, or y>=480-WALL.
  - Sprites cover [x, x+SPRITE) by [y, y+SPRITE).
- Keys:
  - Each key passes through a 2-flop synchroniser, then a rising-edge detector on CLOCK_50.
  - dir encoding: 0 RIGHT, 1 DOWN, 2 LEFT, 3 UP, wrapping mod 4.
  - KEY[2] edge: dir+1. KEY[1] edge: dir-1.
  - Both edges in the same cycle: dir unchanged.
- Frame update, once per frame on pe when hcount=0 and vcount=480 (start of vertical blank):
  - Player moves PSTEP in dir.
  - Player is clamped to x in [16,608] and y in [16,448]; at the limit it stops and dir is kept.
  - Ghost moves GSTEP toward the player independently on each axis; no move on an axis where the coordinates are equal.
  - Ghost move uses the player position before this frame's update.
- Collision:
  - Checked on the same update after movement, using the new positions: |px-gx|<16 and |py-gy|<16.
  - On collision, the positions written are the reset positions (player (304,224) dir RIGHT, ghost (16,16)); these take priority over the moved values.
- Arithmetic: 10-bit unsigned coordinates; clamping is done before any wrap can occur.
- Reset mid-frame: everything returns to reset values on the next CLOCK_50 edge, and timing restarts at (0,0).

Decomposition:
- Shared package vga_pkg holds:
  - horizontal and vertical timing constants (visible, fp, sync, bp, total);
  - colour constants;
  - arena limits;
  - dir typedef (2-bit enum RIGHT/DOWN/LEFT/UP).
- One sub-module, vga_timing:
  - inputs: CLOCK_50, reset, pe;
  - outputs: hcount, vcount, hs, vs, visible, frame_tick.
- Game and render logic stay in the top.

Test Plan:
- Reset, then KEY=3'b000 → VGA_SYNC=0 at all times, VGA_CLK period is 2 CLOCK_50 cycles, RGB=0 while VGA_BLANK=0.
- Sync timing → VGA_HS low for 192 CLOCK_50 cycles out of every 1600; VGA_VS low for 3200 cycles out of every 840000; VGA_BLANK high for 1280 cycles per visible line.
- Idle one frame → player x 304→306, y=224. Pixel at (310,230) is yellow; (5,5) is blue; (100,100) is black.
- Pulse KEY[2] for 4 cycles, then run one frame → dir=DOWN, player at (304,226). Pulse KEY[1] → dir=RIGHT. Pulse both simultaneously → dir unchanged.
- Steer UP and run 120 frames → py clamps at 16 and stays there; dir stays UP.
- Leave idle until the ghost overlaps the player → on that frame update, positions revert to (304,224) and (16,16) with dir=RIGHT.
